// File: rtl/regbank_scan_8_16.sv
// Eight-word register bank feeding an 8:1 word mux, with a sequencer that
// walks the select through all eight words after a start request.
module regbank_scan_8_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] d4,
  output logic [WIDTH-1:0] d5,
  output logic [WIDTH-1:0] d6,
  output logic [WIDTH-1:0] d7,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       sel_reg, sel_next;
  logic [WIDTH-1:0] regs_w [8];

  // Each word is a plain flop bank so it can be cleared by the async reset.
  for (genvar gi = 0; gi < 8; gi++) begin : g_word
    logic [WIDTH-1:0] word_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        word_reg <= '0;
      end else if (wr_en && (wr_addr == 3'(gi))) begin
        word_reg <= wr_data;
      end
    end

    assign regs_w[gi] = word_reg;
  end

  assign d0 = regs_w[0];
  assign d1 = regs_w[1];
  assign d2 = regs_w[2];
  assign d3 = regs_w[3];
  assign d4 = regs_w[4];
  assign d5 = regs_w[5];
  assign d6 = regs_w[6];
  assign d7 = regs_w[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      sel_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
    end
  end

  // The select never wraps inside a scan; it returns to 0 only when leaving SCAN.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    case (state_reg)
      ST_IDLE: begin
        sel_next = 3'd0;
        if (start) begin
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (sel_reg == 3'd7) begin
          state_next = ST_DONE;
          sel_next   = 3'd0;
        end else begin
          sel_next = sel_reg + 3'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        sel_next   = 3'd0;
      end
      default: begin
        state_next = ST_IDLE;
        sel_next   = 3'd0;
      end
    endcase
  end

  always_comb begin
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_reg)
      ST_SCAN: begin
        valid = 1'b1;
        busy  = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign s0 = sel_reg[2];
  assign s1 = sel_reg[1];
  assign s2 = sel_reg[0];

endmodule

// File: tb/tb_regbank_scan_8_16.sv
// Scoreboard bench: stimulus queues expected scan words, a negedge monitor
// pops and compares them against the mux output built from d0..d7 and s0..s2.
module tb_regbank_scan_8_16;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic [15:0] d_w [8];
  logic        s0, s1, s2;
  logic        valid, busy, done;
  logic [15:0] mux_out;

  int n_cmp = 0;
  int n_mis = 0;
  int idle_cnt = 0;

  typedef struct {
    bit          is_done;
    int          sel;
    logic [15:0] data;
    int          idle_before;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  regbank_scan_8_16 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .d0      (d_w[0]),
    .d1      (d_w[1]),
    .d2      (d_w[2]),
    .d3      (d_w[3]),
    .d4      (d_w[4]),
    .d5      (d_w[5]),
    .d6      (d_w[6]),
    .d7      (d_w[7]),
    .s0      (s0),
    .s1      (s1),
    .s2      (s2),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  // Downstream combinational 8:1 word mux
  assign mux_out = d_w[{s0, s1, s2}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_scan(input logic [127:0] words, input int idle0);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.is_done     = 1'b0;
      e.sel         = k;
      e.data        = words[k*16 +: 16];
      e.idle_before = (k == 0) ? idle0 : -1;
      exp_q.push_back(e);
    end
    e.is_done     = 1'b1;
    e.sel         = 0;
    e.data        = 16'd0;
    e.idle_before = -1;
    exp_q.push_back(e);
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] v);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = v;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 8; k++) check($sformatf("%s_d%0d", tag, k), 32'(d_w[k]), 32'd0);
    check({tag, "_sel"},   {29'd0, s0, s1, s2}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every valid or done cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {30'd0, valid, done}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_flag",  {31'd0, done},  {31'd0, mon_e.is_done});
          check("valid_flag", {31'd0, valid}, {31'd0, ~mon_e.is_done});
          check("busy_flag",  {31'd0, busy},  32'd1);
          check("sel_bits",   {29'd0, s0, s1, s2}, mon_e.sel);
          if (!mon_e.is_done) check("mux_word", 32'(mux_out), 32'(mon_e.data));
          if (mon_e.idle_before >= 0) check("idle_gap", idle_cnt, mon_e.idle_before);
          $display("[%0t] sel=%0d word=%0d valid=%0b done=%0b", $time,
                   {s0, s1, s2}, mux_out, valid, done);
        end
        idle_cnt = 0;
      end else if (!busy) begin
        idle_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'd0; start = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Fill with scratch values, then clear them with a mid-cycle reset
    for (int i = 0; i < 8; i++) write_word(3'(i), 16'hA5A0 + 16'(i));
    check("write_d3", 32'(d_w[3]), 32'h0000A5A3);
    check("write_d7", 32'(d_w[7]), 32'h0000A5A7);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_idle");
    tick();
    rst = 1'b0;

    write_word(3'd0, 16'd13); write_word(3'd1, 16'd18);
    write_word(3'd2, 16'd24); write_word(3'd3, 16'd33);
    write_word(3'd4, 16'd55); write_word(3'd5, 16'd66);
    write_word(3'd6, 16'd77); write_word(3'd7, 16'd88);
    tick();

    // Scan 1: word 5 overwritten at sel=2, word 1 overwritten at sel=4,
    // extra start pulses at sel=3 and in DONE must be ignored.
    push_scan({16'd88, 16'd77, 16'd100, 16'd55, 16'd33, 16'd24, 16'd18, 16'd13}, -1);
    start = 1'b1; tick();              // sel0
    start = 1'b0; tick();              // sel1
    tick();                            // sel2
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'd100;
    tick();                            // sel3
    wr_en = 1'b0; start = 1'b1;
    tick();                            // sel4
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'd200;
    tick();                            // sel5
    wr_en = 1'b0;
    tick(); tick(); tick();            // sel6, sel7, DONE
    start = 1'b1; tick();              // IDLE
    start = 1'b0;
    tick(); tick(); tick();
    wait_drain(4);

    // Start held high: back-to-back scans with exactly one IDLE cycle between
    push_scan({16'd88, 16'd77, 16'd100, 16'd55, 16'd33, 16'd24, 16'd200, 16'd13}, -1);
    push_scan({16'd88, 16'd77, 16'd100, 16'd55, 16'd33, 16'd24, 16'd200, 16'd13}, 1);
    start = 1'b1; tick();
    for (int i = 0; i < 10; i++) tick();
    start = 1'b0;
    wait_drain(14);
    tick(); tick();

    // Reset at sel=5: no further words, no done
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back('{1'b0, k, (k == 0) ? 16'd13 : (k == 1) ? 16'd200 :
                       (k == 2) ? 16'd24 : (k == 3) ? 16'd33 : 16'd55, -1});
    end
    start = 1'b1; tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1 check_all_zero("rst_scan");
    check("aborted_scan_consumed", 32'(exp_q.size()), 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();

    push_scan(128'd0, -1);
    start = 1'b1; tick();
    start = 1'b0;
    wait_drain(14);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
